accumulator_diff: RTL and testbench
===================================

# accumulator_diff

Inverse of the Accumulator: recovers the per-sample increment stream from a running modulo-2^WIDTH sum stream by differencing consecutive accepted sums. It sits at the receive end of an accumulated-data link and feeds downstream consumers through a valid/ready output with a two-entry buffer. For an Accumulator fed Din(n) from reset, feeding its Dout(n) into this block reproduces Din(n) exactly, including across wrap-around.

## Interface
- WIDTH, 12, sample width in bits
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous reset, active-low
- Clr  in  1  synchronous restart of difference history (prev := 0), queued outputs kept
- Ce  in  1  input valid; sample accepted on cycle where Ce && Rdy
- Din  in  WIDTH  accumulated sum sample
- Rdy  out  1  block can accept a sample this cycle
- Dout  out  WIDTH  recovered increment
- Vld  out  1  Dout valid; held with Dout stable until Ack
- Ack  in  1  downstream accepts Dout on Vld && Ack
- Wrap  out  1  (ACC_DIFF_WRAP_EN only) accompanies Dout: sum wrapped for this sample
- WrapCnt  out  8  (ACC_DIFF_WRAP_EN only) saturating wrap count

## Operation
- Accept: diff = (Din - prev) mod 2^WIDTH; prev := Din. Unsigned WIDTH-bit subtract, borrow discarded.
- prev reset value 0, so first sample after reset or Clr passes through unchanged.
- Wrap bit for a sample = (Din < prev), unsigned compare, using pre-update prev.
- Clr && accept same cycle: Clr applied first; sample differenced against 0, prev := Din.
- Output buffer FSM, states EMPTY, ONE, TWO (output reg, output reg + skid):
  - EMPTY: accept -> ONE.
  - ONE: accept && !Ack -> TWO (new result to skid); accept && Ack -> ONE (new result to output reg); !accept && Ack -> EMPTY.
  - TWO: Ack -> ONE (skid moves to output reg); no accept possible.
- Rdy = (state != TWO); combinational from state only, never from Ce or Ack.
- Vld = (state != EMPTY). Ordering strictly FIFO; no sample dropped or duplicated.
- Ce while !Rdy: ignored, prev unchanged.

## Timing
- Reset (RST low at edge): state EMPTY, prev 0, Dout 0, Vld 0, Rdy 1, Wrap 0, WrapCnt 0. Reset mid-operation discards both buffer entries.
- Latency: sample accepted at edge k appears on Dout/Vld after edge k (one cycle) when buffer was EMPTY, or ONE with Ack.
- Throughput: one sample per cycle while Ack held high.
- Ack with Vld low has no effect.
- Clr with no accept: affects prev only; does not touch Vld, Dout, state, WrapCnt.

## Configuration
- ACC_DIFF_WRAP_EN defined: Wrap and WrapCnt ports present; Wrap stored alongside each buffered result; WrapCnt increments on every accept with wrap, saturates at 255, cleared by RST only (not Clr).
- Undefined: ports, compare and counter absent; data path and timing identical.

## Structure
- Package acc_pkg: ACC_WIDTH = 12 default constant, FSM state typedef (EMPTY, ONE, TWO), WrapCnt width constant.
- Sub-module acc_diff_skid: two-entry output buffer plus FSM, payload width WIDTH (+1 with wrap); top holds prev register, subtractor, wrap logic.

## Test plan
- Sums 0x480, 0xDDC, 0xEF2 on consecutive cycles, Ack=1 -> Dout 0x480, 0x95C, 0x116, one cycle after each accept, Vld continuous.
- prev 0xEF2, Din 0xB49 -> Dout 0xC57, Wrap 1, WrapCnt 0->1; 256 wrapping samples -> WrapCnt holds 255.
- Ce held high, Ack low 3 cycles -> two accepts, Rdy 0 from the second; Dout frozen at first result; Ack high -> results drain in order, Rdy returns 1 next cycle.
- After sums 0x100, 0x300, Clr && Ce with Din 0x050 -> Dout 0x050; next Din 0x070 -> Dout 0x020.
- RST low with buffer in TWO -> next cycle Vld 0, Rdy 1, Dout 0; next Din 0x123 -> Dout 0x123.
- Ce low, Ack toggling, Clr pulsed with buffer EMPTY -> Vld stays 0, no spurious outputs.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared constants and FSM state type for the accumulator differencer.
// Pure declarations; no timing or backpressure of its own.
// Imported by accumulator_diff and acc_diff_skid.
package acc_pkg;
    localparam int ACC_WIDTH  = 12;
    localparam int WRAPCNT_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } acc_state_e;
endpackage

// File: rtl/acc_diff_skid.sv
// Two-entry output buffer (output reg + skid) with EMPTY/ONE/TWO FSM.
// Latency: a result written while EMPTY (or ONE with ack) is on out_dat one cycle later.
// Backpressure: in_rdy deasserts only in TWO and depends on state alone.
module acc_diff_skid
    import acc_pkg::*;
#(
    parameter int W = ACC_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_ack
);
    acc_state_e state, next_state;
    logic [W-1:0] out_reg, skid_reg;
    logic accept, load_out_in, load_out_skid, load_skid;

    assign in_rdy  = (state != TWO);
    assign out_vld = (state != EMPTY);
    assign out_dat = out_reg;
    assign accept  = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state  = ONE;
                    load_out_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && !out_ack) begin
                    next_state = TWO;
                    load_skid  = 1'b1;
                end else if (accept && out_ack) begin
                    load_out_in = 1'b1;
                end else if (out_ack) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                if (out_ack) begin
                    next_state    = ONE;
                    load_out_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            if (load_out_in)        out_reg <= in_dat;
            else if (load_out_skid) out_reg <= skid_reg;
            if (load_skid)          skid_reg <= in_dat;
        end
    end
endmodule

// File: rtl/accumulator_diff.sv
// Recovers per-sample increments from a modulo-2^WIDTH running sum; optional ACC_DIFF_WRAP_EN adds Wrap/WrapCnt.
// Latency: one cycle from accept to Dout/Vld when the buffer has room for direct output.
// Backpressure: Rdy low only while both buffer entries are full; Ce is ignored then.
module accumulator_diff
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Clr,
    input  logic                 Ce,
    input  logic [WIDTH-1:0]     Din,
    output logic                 Rdy,
    output logic [WIDTH-1:0]     Dout,
    output logic                 Vld,
    input  logic                 Ack
`ifdef ACC_DIFF_WRAP_EN
    ,
    output logic                 Wrap,
    output logic [WRAPCNT_W-1:0] WrapCnt
`endif
);
    logic [WIDTH-1:0] prev, prev_eff, diff;
    logic accept;

    assign accept   = Ce && Rdy;
    // Clr restarts history before the same-cycle sample is differenced
    assign prev_eff = Clr ? '0 : prev;
    assign diff     = Din - prev_eff;

    always_ff @(posedge CLK) begin
        if (!RST)        prev <= '0;
        else if (accept) prev <= Din;
        else if (Clr)    prev <= '0;
    end

`ifdef ACC_DIFF_WRAP_EN
    logic           wrap;
    logic [WIDTH:0] buf_dat;

    assign wrap = (Din < prev_eff);
    assign Dout = buf_dat[WIDTH-1:0];
    assign Wrap = buf_dat[WIDTH];

    always_ff @(posedge CLK) begin
        if (!RST)
            WrapCnt <= '0;
        else if (accept && wrap && (WrapCnt != {WRAPCNT_W{1'b1}}))
            WrapCnt <= WrapCnt + 1'b1;
    end

    acc_diff_skid #(.W(WIDTH + 1)) u_skid (
        .clk     (CLK),
        .rst_n   (RST),
        .in_vld  (Ce),
        .in_dat  ({wrap, diff}),
        .in_rdy  (Rdy),
        .out_vld (Vld),
        .out_dat (buf_dat),
        .out_ack (Ack)
    );
`else
    acc_diff_skid #(.W(WIDTH)) u_skid (
        .clk     (CLK),
        .rst_n   (RST),
        .in_vld  (Ce),
        .in_dat  (diff),
        .in_rdy  (Rdy),
        .out_vld (Vld),
        .out_dat (Dout),
        .out_ack (Ack)
    );
`endif
endmodule

// File: tb/tb_accumulator_diff.sv
// Directed bench for accumulator_diff; wrap checks apply when ACC_DIFF_WRAP_EN is defined.
module tb_accumulator_diff;
    localparam int W = 12;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Clr = 1'b0;
    logic         Ce  = 1'b0;
    logic [W-1:0] Din = '0;
    logic         Ack = 1'b0;
    logic         Rdy, Vld;
    logic [W-1:0] Dout;
`ifdef ACC_DIFF_WRAP_EN
    logic         Wrap;
    logic [7:0]   WrapCnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    accumulator_diff dut (
        .CLK  (CLK),
        .RST  (RST),
        .Clr  (Clr),
        .Ce   (Ce),
        .Din  (Din),
        .Rdy  (Rdy),
        .Dout (Dout),
        .Vld  (Vld),
        .Ack  (Ack)
`ifdef ACC_DIFF_WRAP_EN
        ,
        .Wrap    (Wrap),
        .WrapCnt (WrapCnt)
`endif
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        tick; tick;
        RST = 1'b1;
        check("rst_vld", 32'(Vld), 32'd0);
        check("rst_rdy", 32'(Rdy), 32'd1);
        check("rst_dout", 32'(Dout), 32'h000);
`ifdef ACC_DIFF_WRAP_EN
        check("rst_wrap", 32'(Wrap), 32'd0);
        check("rst_wrapcnt", 32'(WrapCnt), 32'd0);
`endif

        // Streaming with Ack held high
        Ack = 1'b1; Ce = 1'b1; Din = 12'h480;
        tick;
        check("s1_vld", 32'(Vld), 32'd1);
        check("s1_dout", 32'(Dout), 32'h480);
        Din = 12'hDDC;
        tick;
        check("s2_vld", 32'(Vld), 32'd1);
        check("s2_dout", 32'(Dout), 32'h95C);
        Din = 12'hEF2;
        tick;
        check("s3_vld", 32'(Vld), 32'd1);
        check("s3_dout", 32'(Dout), 32'h116);
        Ce = 1'b0;
        tick;
        check("s_drain_vld", 32'(Vld), 32'd0);

        // Wrap-around sample
        Ce = 1'b1; Din = 12'hB49;
        tick;
        check("wrap_dout", 32'(Dout), 32'hC57);
`ifdef ACC_DIFF_WRAP_EN
        check("wrap_bit", 32'(Wrap), 32'd1);
        check("wrap_cnt1", 32'(WrapCnt), 32'd1);
`endif
        // 256 more wrapping samples: each one step below the previous
        for (int i = 0; i < 256; i++) begin
            Din = 12'hB48 - 12'(i);
            tick;
        end
        check("sat_dout", 32'(Dout), 32'hFFF);
`ifdef ACC_DIFF_WRAP_EN
        check("sat_wrapcnt", 32'(WrapCnt), 32'd255);
`endif
        Ce = 1'b0;
        tick;

        // Backpressure: prev is now 0xA49
        Ack = 1'b0; Ce = 1'b1; Din = 12'hA59;
        tick;
        check("bp1_dout", 32'(Dout), 32'h010);
        check("bp1_rdy", 32'(Rdy), 32'd1);
        Din = 12'hA79;
        tick;
        check("bp2_rdy", 32'(Rdy), 32'd0);
        check("bp2_dout", 32'(Dout), 32'h010);
        Din = 12'hAAA;
        tick;
        check("bp3_rdy", 32'(Rdy), 32'd0);
        check("bp3_dout", 32'(Dout), 32'h010);
        check("bp3_vld", 32'(Vld), 32'd1);
        Ack = 1'b1;
        tick;
        check("bp_drain1_dout", 32'(Dout), 32'h020);
        check("bp_drain1_rdy", 32'(Rdy), 32'd1);
        tick;
        check("bp_drain2_dout", 32'(Dout), 32'h031);
        Ce = 1'b0;
        tick;
        check("bp_drain_vld", 32'(Vld), 32'd0);

        // Clr together with accept
        Ce = 1'b1; Din = 12'h100;
        tick;
        check("clr_pre1", 32'(Dout), 32'h656);
        Din = 12'h300;
        tick;
        check("clr_pre2", 32'(Dout), 32'h200);
        Clr = 1'b1; Din = 12'h050;
        tick;
        check("clr_dout", 32'(Dout), 32'h050);
        Clr = 1'b0; Din = 12'h070;
        tick;
        check("clr_next", 32'(Dout), 32'h020);
        Ce = 1'b0;
        tick;

        // Reset with buffer full
        Ack = 1'b0; Ce = 1'b1; Din = 12'h100;
        tick;
        Din = 12'h200;
        tick;
        check("rst2_pre_rdy", 32'(Rdy), 32'd0);
        RST = 1'b0; Ce = 1'b0;
        tick;
        RST = 1'b1;
        check("rst2_vld", 32'(Vld), 32'd0);
        check("rst2_rdy", 32'(Rdy), 32'd1);
        check("rst2_dout", 32'(Dout), 32'h000);
`ifdef ACC_DIFF_WRAP_EN
        check("rst2_wrapcnt", 32'(WrapCnt), 32'd0);
`endif
        Ack = 1'b1; Ce = 1'b1; Din = 12'h123;
        tick;
        check("rst2_dout_new", 32'(Dout), 32'h123);
        Ce = 1'b0;
        tick;

        // Idle: Ack toggling and Clr pulsed with buffer empty
        for (int i = 0; i < 4; i++) begin
            Ack = i[0];
            Clr = (i == 1);
            tick;
            check("idle_vld", 32'(Vld), 32'd0);
        end
        Clr = 1'b0;
        // Clr above cleared history, so this sample passes unchanged
        Ack = 1'b1; Ce = 1'b1; Din = 12'h200;
        tick;
        check("idle_clr_dout", 32'(Dout), 32'h200);
        Ce = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
